// File: rtl/sram_np_pkg.sv
// rtl/sram_np_pkg.sv - shared types and geometry helpers for the tagged N-port SRAM
package sram_np_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_e;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    // Ports address whole words, so the byte-offset bits drop out of the address.
    function automatic int word_aw(input int addr_width, input int data_width);
        return addr_width - $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/sram_np_tagged_if.sv
// rtl/sram_np_tagged_if.sv - per-port request/response bundle of the tagged SRAM
interface sram_np_tagged_if
    import sram_np_pkg::*;
#(
    parameter int NumPorts  = 2,
    parameter int DataWidth = 32,
    parameter int WordAw    = 15
);
    localparam int BeWidth = be_width(DataWidth);

    logic [NumPorts-1:0]           req_i;
    logic [NumPorts-1:0]           gnt_o;
    logic [NumPorts-1:0]           we_i;
    logic [NumPorts*BeWidth-1:0]   be_i;
    logic [NumPorts*WordAw-1:0]    addr_i;
    logic [NumPorts*DataWidth-1:0] wdata_i;
    logic [NumPorts-1:0]           wcap_i;
    logic [NumPorts-1:0]           rvalid_o;
    logic [NumPorts*DataWidth-1:0] rdata_o;
    logic [NumPorts-1:0]           rcap_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i, wcap_i,
        input  gnt_o, rvalid_o, rdata_o, rcap_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i, wcap_i,
        output gnt_o, rvalid_o, rdata_o, rcap_o
    );

endinterface

// File: rtl/sram_rr_arb.sv
// rtl/sram_rr_arb.sv - round-robin single-grant arbiter with a forced no-grant hold
module sram_rr_arb #(
    parameter  int NumPorts = 2,
    localparam int IdxW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumPorts-1:0] req,
    input  logic                hold,
    output logic [NumPorts-1:0] gnt,
    output logic                gnt_valid,
    output logic [IdxW-1:0]     gnt_idx
);

    logic [IdxW-1:0] ptr_q;
    int              cand;

    // Search starts just after the last winner so every requester is served in turn.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        gnt_idx   = ptr_q;
        cand      = 0;
        for (int i = 1; i <= NumPorts; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NumPorts) cand = cand - NumPorts;
            if (!gnt_valid && !hold && req[IdxW'(cand)]) begin
                gnt_valid          = 1'b1;
                gnt[IdxW'(cand)]   = 1'b1;
                gnt_idx            = IdxW'(cand);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= IdxW'(NumPorts - 1);
        end else if (gnt_valid) begin
            ptr_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/sram_np_tagged.sv
// rtl/sram_np_tagged.sv - N-port word SRAM with per-word capability tag and tag-sweep engine
module sram_np_tagged
    import sram_np_pkg::*;
#(
    parameter int AddrWidth     = 17,
    parameter int DataWidth     = 32,
    parameter int NumPorts      = 2,
    parameter int MaxSweepStall = 15
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    sram_np_tagged_if.slave  bus,
    input  logic             sweep_start_i,
    output logic             sweep_busy_o,
    output logic             sweep_done_o
);

    localparam int WordAw  = word_aw(AddrWidth, DataWidth);
    localparam int BeWidth = be_width(DataWidth);
    localparam int Depth   = 2 ** WordAw;
    localparam int IdxW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int StallW  = (MaxSweepStall > 0) ? $clog2(MaxSweepStall + 1) : 1;

    logic [DataWidth-1:0] mem     [Depth];
    logic                 tag_mem [Depth];

    logic                 gnt_valid;
    logic [IdxW-1:0]      gnt_idx;
    logic                 sweep_hold;
    logic                 sel_we;
    logic [BeWidth-1:0]   sel_be;
    logic [WordAw-1:0]    sel_addr;
    logic [DataWidth-1:0] sel_wdata;
    logic                 sel_wcap;

    sweep_state_e         state_q, state_d;
    logic [WordAw-1:0]    cnt_q, cnt_d;
    logic [StallW-1:0]    stall_q, stall_d;
    logic                 done_q, done_d;
    logic                 sweep_clr;

    // Holding during reset keeps gnt_o low while rst_ni is asserted.
    sram_rr_arb #(.NumPorts(NumPorts)) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req       (bus.req_i),
        .hold      (sweep_hold || !rst_ni),
        .gnt       (bus.gnt_o),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign sel_we    = bus.we_i[gnt_idx];
    assign sel_be    = bus.be_i[int'(gnt_idx) * BeWidth +: BeWidth];
    assign sel_addr  = bus.addr_i[int'(gnt_idx) * WordAw +: WordAw];
    assign sel_wdata = bus.wdata_i[int'(gnt_idx) * DataWidth +: DataWidth];
    assign sel_wcap  = bus.wcap_i[gnt_idx];

    // After MaxSweepStall lost cycles the sweep steals one cycle from the ports.
    assign sweep_hold = (state_q == SWEEP) && (stall_q == StallW'(MaxSweepStall));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_d   = stall_q;
        done_d    = 1'b0;
        sweep_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (sweep_start_i) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                    stall_d = '0;
                end
            end
            SWEEP: begin
                if (!gnt_valid) begin
                    sweep_clr = 1'b1;
                    stall_d   = '0;
                    cnt_d     = cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stall_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            done_q  <= done_d;
        end
    end

    assign sweep_busy_o = (state_q == SWEEP);
    assign sweep_done_o = done_q;

    // Array contents survive reset; only writes are suppressed while it is held.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (gnt_valid && sel_we) begin
                for (int b = 0; b < BeWidth; b++) begin
                    if (sel_be[b]) mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
                if (&sel_be) begin
                    tag_mem[sel_addr] <= sel_wcap;
                end else if (|sel_be) begin
                    tag_mem[sel_addr] <= 1'b0;
                end
            end else if (sweep_clr) begin
                tag_mem[cnt_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bus.rvalid_o <= '0;
            bus.rdata_o  <= '0;
            bus.rcap_o   <= '0;
        end else begin
            bus.rvalid_o <= '0;
            if (gnt_valid && !sel_we) begin
                bus.rvalid_o[gnt_idx]                                <= 1'b1;
                bus.rdata_o[int'(gnt_idx) * DataWidth +: DataWidth] <= mem[sel_addr];
                bus.rcap_o[gnt_idx]                                  <= tag_mem[sel_addr];
            end
        end
    end

endmodule
